// File: rtl/approx_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_monitor
//
// Streaming error-metric collector for approximate compressor/multiplier
// outputs. Each accepted exact/approx pair yields an error distance
// ED = |exact - approx|. Per-run statistics are accumulated: sample count,
// erroneous-sample count, saturating ED sum and (optionally) the maximum ED.
// Software derives the error rate and mean error distance from these counters.
//
// Optional feature macro: APPROX_ERR_MAX_EN
//   defined   : max_ed tracking register and comparator are built.
//   undefined : max_ed is tied to 0; all other behaviour is unchanged.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      pulse: clear statistics, begin a run of n_samples
//   n_samples  in   CNT_W  run length, latched on the accepted start
//   in_valid   in   1      exact/approx pair valid
//   in_ready   out  1      monitor accepts a pair this cycle
//   exact      in   W      exact reference result
//   approx     in   W      approximate result
//   busy       out  1      high while a run is in progress
//   done       out  1      level, high after a run completes until next start
//   sample_cnt out  CNT_W  pairs accepted in this run
//   err_cnt    out  CNT_W  accepted pairs with ED != 0
//   sum_ed     out  ACC_W  saturating sum of ED
//   sum_sat    out  1      sticky: sum_ed saturated during this run
//   max_ed     out  W      largest ED in this run (0 when feature disabled)
//
// State visibility: {busy, done} encodes the FSM state directly
//   00 = IDLE, 10 = RUN, 01 = DONE.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (never on in_valid), so the
// producer may hold in_valid high and simply wait for in_ready.
// ---------------------------------------------------------------------------
module approx_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact,
  input  logic [W-1:0]     approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sum_sat,
  output logic [W-1:0]     max_ed
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] n_lat_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W-1:0] sum_q;
  logic             sat_q;

  // Stage-1 pipeline register: ED of the pair accepted on the previous edge.
  logic             v1_q;
  logic [W-1:0]     ed1_q;

`ifdef APPROX_ERR_MAX_EN
  logic [W-1:0]     max_q;
`endif

  logic             accept;
  logic [W-1:0]     ed_d;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_d;
  logic             sum_ovf;

  // Counter bound guarantees sample_cnt never exceeds n_lat, so no wrap.
  assign in_ready = (state_q == S_RUN) && (sample_cnt_q < n_lat_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    ed_d    = '0;
    sum_ext = '0;
    sum_d   = '0;
    sum_ovf = 1'b0;
    ed_d    = (exact >= approx) ? (exact - approx) : (approx - exact);
    // One extra carry bit detects overflow; on overflow clamp to all ones.
    sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - W){1'b0}}, ed1_q};
    sum_ovf = sum_ext[ACC_W];
    sum_d   = sum_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_lat_q      <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_q        <= '0;
      sat_q        <= 1'b0;
      v1_q         <= 1'b0;
      ed1_q        <= '0;
`ifdef APPROX_ERR_MAX_EN
      max_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Statistics hold here until a new run is started.
          if (start) begin
            state_q      <= S_RUN;
            n_lat_q      <= n_samples;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            sat_q        <= 1'b0;
            v1_q         <= 1'b0;
            ed1_q        <= '0;
`ifdef APPROX_ERR_MAX_EN
            max_q        <= '0;
`endif
          end
        end

        S_RUN: begin
          // Stage 1: capture ED of the accepted pair.
          v1_q <= accept;
          if (accept) begin
            ed1_q        <= ed_d;
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
          end

          // Stage 2: fold the stage-1 ED into the statistics.
          if (v1_q) begin
            sum_q <= sum_d;
            if (sum_ovf) begin
              sat_q <= 1'b1;
            end
            if (ed1_q != '0) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
`ifdef APPROX_ERR_MAX_EN
            if (ed1_q > max_q) begin
              max_q <= ed1_q;
            end
`endif
          end

          // All pairs taken and nothing left in stage 1: run is complete.
          // in_ready is low here, so no new accept can race this exit.
          if ((sample_cnt_q == n_lat_q) && !v1_q) begin
            state_q <= S_DONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_q;
  assign sum_sat    = sat_q;

`ifdef APPROX_ERR_MAX_EN
  assign max_ed = max_q;
`else
  assign max_ed = '0;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
module tb_approx_err_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] n_samples;
  logic        in_valid;
  logic [7:0]  exact;
  logic [7:0]  approx;

  // DUT A: wide accumulator
  logic        a_in_ready, a_busy, a_done, a_sum_sat;
  logic [15:0] a_sample_cnt, a_err_cnt;
  logic [31:0] a_sum_ed;
  logic [7:0]  a_max_ed;

  // DUT B: 8-bit accumulator to exercise saturation
  logic        b_in_ready, b_busy, b_done, b_sum_sat;
  logic [15:0] b_sample_cnt, b_err_cnt;
  logic [7:0]  b_sum_ed;
  logic [7:0]  b_max_ed;

  approx_err_monitor #(.W(8), .CNT_W(16), .ACC_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(a_in_ready), .exact(exact), .approx(approx),
    .busy(a_busy), .done(a_done), .sample_cnt(a_sample_cnt), .err_cnt(a_err_cnt),
    .sum_ed(a_sum_ed), .sum_sat(a_sum_sat), .max_ed(a_max_ed)
  );

  approx_err_monitor #(.W(8), .CNT_W(16), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(b_in_ready), .exact(exact), .approx(approx),
    .busy(b_busy), .done(b_done), .sample_cnt(b_sample_cnt), .err_cnt(b_err_cnt),
    .sum_ed(b_sum_ed), .sum_sat(b_sum_sat), .max_ed(b_max_ed)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] cnt;
    logic [15:0] err;
    logic [31:0] sum32;
    logic        sat32;
    logic [7:0]  sum8;
    logic        sat8;
    logic [7:0]  mx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] ex_a [64];
  logic [7:0] ap_a [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: statistics of a whole run computed from the pair list.
  task automatic push_expect(input int n);
    exp_t   e;
    longint tot = 0;
    int     errs = 0;
    int     mx = 0;
    for (int i = 0; i < n; i++) begin
      int a = int'(ex_a[i]);
      int b = int'(ap_a[i]);
      int ed = (a >= b) ? (a - b) : (b - a);
      tot += ed;
      if (ed != 0) errs++;
      if (ed > mx) mx = ed;
    end
    e.cnt   = 16'(n);
    e.err   = 16'(errs);
    e.sat32 = (tot > 64'd4294967295);
    e.sum32 = e.sat32 ? 32'hFFFF_FFFF : 32'(tot);
    e.sat8  = (tot > 64'd255);
    e.sum8  = e.sat8 ? 8'd255 : 8'(tot);
`ifdef APPROX_ERR_MAX_EN
    e.mx    = 8'(mx);
`else
    e.mx    = 8'd0;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: on each rising edge of done, pop the expected run result.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (a_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no completed run (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("a_sample_cnt", 64'(a_sample_cnt), 64'(e.cnt));
        check("a_err_cnt",    64'(a_err_cnt),    64'(e.err));
        check("a_sum_ed",     64'(a_sum_ed),     64'(e.sum32));
        check("a_sum_sat",    64'(a_sum_sat),    64'(e.sat32));
        check("a_max_ed",     64'(a_max_ed),     64'(e.mx));
        check("b_done",       64'(b_done),       64'd1);
        check("b_sample_cnt", 64'(b_sample_cnt), 64'(e.cnt));
        check("b_err_cnt",    64'(b_err_cnt),    64'(e.err));
        check("b_sum_ed",     64'(b_sum_ed),     64'(e.sum8));
        check("b_sum_sat",    64'(b_sum_sat),    64'(e.sat8));
        check("b_max_ed",     64'(b_max_ed),     64'(e.mx));
      end
    end
    done_prev = a_done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    n_samples = 16'(n);
    tick();
    start     = 1'b0;
  endtask

  // Sends k of the n pairs of the current run. mode 0: back-to-back,
  // mode 1: bubble every other cycle, mode 2: random bubbles.
  // poke pulses start (with a different n) mid-run; it must be ignored.
  task automatic send_pairs(input int n, input int k, input int mode, input bit poke);
    int guard;
    int lat;
    for (int i = 0; i < k; i++) begin
      if (mode == 1 && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      if (mode == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
      end
      if (poke && i == 3) begin
        start     = 1'b1;
        n_samples = 16'($urandom_range(1, 40));
      end
      in_valid = 1'b1;
      exact    = ex_a[i];
      approx   = ap_a[i];
      guard    = 0;
      while (!a_in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles expected 1");
      end
      tick();
      start = 1'b0;
    end
    if (k == n) begin
      // Keep offering a pair: the monitor must refuse it.
      check("a_in_ready_drop", 64'(a_in_ready), 64'd0);
      check("b_in_ready_drop", 64'(b_in_ready), 64'd0);
      in_valid = 1'b0;
      lat = 0;
      while (!a_done && lat < 10) begin
        tick();
        lat++;
      end
      // Last accept edge, then stage-2 edge, then DONE on the following edge.
      check("done_latency", 64'(lat), 64'd2);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic run_n(input int n, input int mode, input bit poke);
    push_expect(n);
    do_start(n);
    if (n == 0) begin
      check("n0_busy",     64'(a_busy),     64'd1);
      check("n0_b_busy",   64'(b_busy),     64'd1);
      check("n0_in_ready", 64'(a_in_ready), 64'd0);
      tick();
      check("n0_done",     64'(a_done),     64'd1);
    end else begin
      send_pairs(n, n, mode, poke);
    end
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     64'(a_busy),       64'd0);
    check({tag, "_done"},     64'(a_done),       64'd0);
    check({tag, "_in_ready"}, 64'(a_in_ready),   64'd0);
    check({tag, "_cnt"},      64'(a_sample_cnt), 64'd0);
    check({tag, "_err"},      64'(a_err_cnt),    64'd0);
    check({tag, "_sum"},      64'(a_sum_ed),     64'd0);
    check({tag, "_sat"},      64'(a_sum_sat),    64'd0);
    check({tag, "_max"},      64'(a_max_ed),     64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0; exact = '0; approx = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Pairs offered while idle must not be taken.
    in_valid = 1'b1; exact = 8'd17; approx = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_in_ready", 64'(a_in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // Directed run: EDs 0,3,6,255.
    ex_a[0] = 8'd10;  ap_a[0] = 8'd10;
    ex_a[1] = 8'd10;  ap_a[1] = 8'd7;
    ex_a[2] = 8'd3;   ap_a[2] = 8'd9;
    ex_a[3] = 8'd255; ap_a[3] = 8'd0;
    run_n(4, 0, 1'b0);

    // Empty run.
    run_n(0, 0, 1'b0);

    // Saturation on the narrow accumulator.
    for (int i = 0; i < 3; i++) begin
      ex_a[i] = 8'd200; ap_a[i] = 8'd0;
    end
    run_n(3, 0, 1'b0);

    // start pulsed mid-run, bubbles every other cycle.
    for (int i = 0; i < 8; i++) begin
      ex_a[i] = 8'($urandom_range(0, 255));
      ap_a[i] = 8'($urandom_range(0, 255));
    end
    run_n(8, 1, 1'b1);

    // Reset mid-run discards the run.
    for (int i = 0; i < 5; i++) begin
      ex_a[i] = 8'($urandom_range(0, 255));
      ap_a[i] = 8'($urandom_range(0, 255));
    end
    do_start(5);
    send_pairs(5, 2, 0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("midrst");

    ex_a[0] = 8'd5; ap_a[0] = 8'd1;
    run_n(1, 0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      int n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) begin
        ex_a[i] = 8'($urandom_range(0, 255));
        ap_a[i] = ($urandom_range(0, 3) == 0) ? ex_a[i] : 8'($urandom_range(0, 255));
      end
      run_n(n, 2, (n > 5) && ($urandom_range(0, 1) == 1));
    end

    repeat (4) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
